posit_exp_combiner: RTL and testbench
=====================================

POSIT_EXP_COMBINER -- requirements
Module: posit_exp_combiner

Interface
REQ-001 SHALL have parameter ES, default 3: exponent field width.
REQ-002 SHALL have parameter K_BITS, default 6: regime width, signed two's complement.
REQ-003 SHALL have derived parameter RAW_BITS = ES+K_BITS+1: signed result width, one guard bit.
REQ-004 SHALL have port clk, input, 1: clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: request; sampled only in IDLE.
REQ-007 SHALL have port op, input, 1: 0 = multiply (add exponents), 1 = divide (A minus B).
REQ-008 SHALL have ports exp_A and exp_B, input, ES each: unsigned exponent fields.
REQ-009 SHALL have ports k_A and k_B, input, K_BITS each: signed regime values.
REQ-010 SHALL have ports sign_A, sign_B, zero_A, zero_B, nar_A, nar_B, input, 1 each: operand flags.
REQ-011 SHALL have port ack, input, 1: consumer accepts the result.
REQ-012 SHALL have port exp_raw, output, RAW_BITS: signed combined scale.
REQ-013 SHALL have ports k_out (K_BITS) and e_out (ES), output: exp_raw decomposed.
REQ-014 SHALL have ports sign_out, nar_out, zero_out, ovf, unf, output, 1 each.
REQ-015 SHALL have ports done and busy, output, 1 each.

Function
REQ-016 SHALL implement FSM states IDLE, CONV, CALC, DONE.
REQ-017 SHALL transition IDLE->CONV on start=1, capturing op and all operand inputs on that same edge.
REQ-018 SHALL transition CONV->CALC unconditionally.
REQ-019 SHALL transition CALC->DONE unconditionally.
REQ-020 SHALL transition DONE->IDLE on ack=1, otherwise hold DONE.
REQ-021 SHALL compute raw_X = k_X*2^ES + exp_X in CONV, sign-extended to RAW_BITS.
REQ-022 SHALL compute sum = raw_A + raw_B (op=0) or raw_A - raw_B (op=1) in CALC, at RAW_BITS width with no loss.
REQ-023 SHALL define EXP_MAX = (2^(K_BITS-1)-1)*2^ES + 2^ES-1 and EXP_MIN = -2^(K_BITS-1)*2^ES (255 and -256 at defaults).
REQ-024 SHALL on sum > EXP_MAX set exp_raw=EXP_MAX and ovf=1 (saturate to maxpos, not NaR).
REQ-025 SHALL on sum < EXP_MIN set exp_raw=EXP_MIN and unf=1 (saturate to minpos, not zero).
REQ-026 SHALL otherwise set exp_raw=sum with ovf=unf=0.
REQ-027 SHALL apply special-case priority NaR > zero > saturation.
REQ-028 SHALL set nar_out=1 if nar_A or nar_B, or if op=1 and zero_B; then exp_raw=0, sign_out=0, zero_out=ovf=unf=0.
REQ-029 SHALL, when not NaR, set zero_out=1 if zero_A, or if op=0 and zero_B; then exp_raw=0, sign_out=0, ovf=unf=0.
REQ-030 SHALL otherwise set sign_out = sign_A XOR sign_B.
REQ-031 SHALL set k_out = exp_raw arithmetically shifted right by ES, truncated to K_BITS, and e_out = exp_raw[ES-1:0].
REQ-032 SHALL register all result outputs on the CALC->DONE edge: done rises 2 edges after the start-sampling edge.
REQ-033 SHALL hold done=1 and all result outputs stable throughout DONE.
REQ-034 SHALL clear done on the DONE->IDLE edge while result outputs keep their values until the next CALC->DONE edge.
REQ-035 SHALL assert busy=1 whenever the state is not IDLE.
REQ-036 SHALL ignore start outside IDLE, including start coincident with ack in DONE.
REQ-037 SHALL ignore ack outside DONE.

Reset
REQ-038 SHALL on rst_n=0, at any time including mid-operation, force IDLE and clear every output and internal register to 0.
REQ-039 SHALL accept start=1 on the first rising edge after rst_n deasserts.

Verification
REQ-040 SHALL cover mul: k_A=2, exp_A=3, k_B=-1, exp_B=5 -> exp_raw=16, k_out=2, e_out=0, done 2 edges after start.
REQ-041 SHALL cover mul overflow: k_A=31, exp_A=7, k_B=1, exp_B=0 -> exp_raw=255, ovf=1, nar_out=0.
REQ-042 SHALL cover div underflow: k_A=-32, exp_A=0, k_B=1, exp_B=0, op=1 -> exp_raw=-256, unf=1, k_out=-32.
REQ-043 SHALL cover special cases: op=1 with zero_B=1 -> nar_out=1; op=0 with zero_A=1 -> zero_out=1, exp_raw=0; nar_A=1 with zero_B=1 -> nar_out=1, zero_out=0.
REQ-044 SHALL cover handshake: ack low 5 cycles -> done and outputs stable; start pulses while busy -> no effect; ack=1 -> done=0 next edge.
REQ-045 SHALL cover reset: rst_n low during CALC -> outputs 0 and IDLE immediately; a subsequent start completes normally.

Source files
------------

// File: rtl/posit_exp_combiner.sv
// Posit exponent combiner. It merges regime and exponent fields into one signed
// scale, adds or subtracts the two scales, saturates the result and flags special cases.
module posit_exp_combiner #(
  parameter int ES = 3,
  parameter int K_BITS = 6,
  localparam int RAW_BITS = ES + K_BITS + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       op,
  input  logic [ES-1:0]              exp_A,
  input  logic [ES-1:0]              exp_B,
  input  logic signed [K_BITS-1:0]   k_A,
  input  logic signed [K_BITS-1:0]   k_B,
  input  logic                       sign_A,
  input  logic                       sign_B,
  input  logic                       zero_A,
  input  logic                       zero_B,
  input  logic                       nar_A,
  input  logic                       nar_B,
  input  logic                       ack,
  output logic signed [RAW_BITS-1:0] exp_raw,
  output logic signed [K_BITS-1:0]   k_out,
  output logic [ES-1:0]              e_out,
  output logic                       sign_out,
  output logic                       nar_out,
  output logic                       zero_out,
  output logic                       ovf,
  output logic                       unf,
  output logic                       done,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  // The largest scale is 2^(K_BITS-1+ES)-1; the smallest is its negation minus one.
  localparam logic signed [RAW_BITS-1:0] EXP_MAX =
    RAW_BITS'((32'sd1 <<< (K_BITS - 1 + ES)) - 32'sd1);
  localparam logic signed [RAW_BITS-1:0] EXP_MIN =
    RAW_BITS'(-(32'sd1 <<< (K_BITS - 1 + ES)));

  state_t                       state_r;
  logic                         op_r;
  logic [ES-1:0]                exp_a_r, exp_b_r;
  logic signed [K_BITS-1:0]     k_a_r, k_b_r;
  logic                         sign_a_r, sign_b_r, zero_a_r, zero_b_r, nar_a_r, nar_b_r;
  logic signed [RAW_BITS-1:0]   raw_a_r, raw_b_r;

  logic signed [RAW_BITS-1:0]   sum_s, res_s;
  logic                         nar_s, zero_s, ovf_s, unf_s, sign_s;

  // k*2^ES + e is simply the concatenation {k, e}, sign-extended.
  function automatic logic signed [RAW_BITS-1:0] to_raw(
    input logic signed [K_BITS-1:0] k,
    input logic [ES-1:0]            e
  );
    return RAW_BITS'($signed({k, e}));
  endfunction

  // Combine scales, apply NaR > zero > saturation priority.
  always_comb begin
    sum_s  = op_r ? (raw_a_r - raw_b_r) : (raw_a_r + raw_b_r);
    nar_s  = nar_a_r | nar_b_r | (op_r & zero_b_r);
    zero_s = ~nar_s & (zero_a_r | (~op_r & zero_b_r));
    res_s  = {RAW_BITS{1'b0}};
    ovf_s  = 1'b0;
    unf_s  = 1'b0;
    sign_s = 1'b0;
    if (nar_s || zero_s) begin
      res_s = {RAW_BITS{1'b0}};
    end else if (sum_s > EXP_MAX) begin
      res_s  = EXP_MAX;
      ovf_s  = 1'b1;
      sign_s = sign_a_r ^ sign_b_r;
    end else if (sum_s < EXP_MIN) begin
      res_s  = EXP_MIN;
      unf_s  = 1'b1;
      sign_s = sign_a_r ^ sign_b_r;
    end else begin
      res_s  = sum_s;
      sign_s = sign_a_r ^ sign_b_r;
    end
  end

  // Control FSM with operand capture and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      op_r     <= 1'b0;
      exp_a_r  <= {ES{1'b0}};
      exp_b_r  <= {ES{1'b0}};
      k_a_r    <= {K_BITS{1'b0}};
      k_b_r    <= {K_BITS{1'b0}};
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      zero_a_r <= 1'b0;
      zero_b_r <= 1'b0;
      nar_a_r  <= 1'b0;
      nar_b_r  <= 1'b0;
      raw_a_r  <= {RAW_BITS{1'b0}};
      raw_b_r  <= {RAW_BITS{1'b0}};
      exp_raw  <= {RAW_BITS{1'b0}};
      k_out    <= {K_BITS{1'b0}};
      e_out    <= {ES{1'b0}};
      sign_out <= 1'b0;
      nar_out  <= 1'b0;
      zero_out <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r     <= op;
            exp_a_r  <= exp_A;
            exp_b_r  <= exp_B;
            k_a_r    <= k_A;
            k_b_r    <= k_B;
            sign_a_r <= sign_A;
            sign_b_r <= sign_B;
            zero_a_r <= zero_A;
            zero_b_r <= zero_B;
            nar_a_r  <= nar_A;
            nar_b_r  <= nar_B;
            busy     <= 1'b1;
            state_r  <= CONV;
          end
        end
        CONV: begin
          raw_a_r <= to_raw(k_a_r, exp_a_r);
          raw_b_r <= to_raw(k_b_r, exp_b_r);
          state_r <= CALC;
        end
        CALC: begin
          exp_raw  <= res_s;
          k_out    <= res_s[ES+K_BITS-1:ES];
          e_out    <= res_s[ES-1:0];
          sign_out <= sign_s;
          nar_out  <= nar_s;
          zero_out <= zero_s;
          ovf      <= ovf_s;
          unf      <= unf_s;
          done     <= 1'b1;
          state_r  <= DONE;
        end
        DONE: begin
          if (ack) begin
            done    <= 1'b0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posit_exp_combiner.sv
// Bench for posit_exp_combiner: vector table driven through a scoreboard queue,
// plus handshake and mid-operation reset sequences.
module tb_posit_exp_combiner;

  localparam int ES = 3;
  localparam int K  = 6;
  localparam int RB = ES + K + 1;
  localparam int NV = 17;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0, op = 1'b0, ack = 1'b0;
  logic [ES-1:0]        exp_A = '0, exp_B = '0;
  logic signed [K-1:0]  k_A = '0, k_B = '0;
  logic                 sign_A = 1'b0, sign_B = 1'b0, zero_A = 1'b0, zero_B = 1'b0;
  logic                 nar_A = 1'b0, nar_B = 1'b0;
  logic signed [RB-1:0] exp_raw;
  logic signed [K-1:0]  k_out;
  logic [ES-1:0]        e_out;
  logic                 sign_out, nar_out, zero_out, ovf, unf, done, busy;

  typedef struct {
    logic                 op;
    logic [ES-1:0]        ea, eb;
    logic signed [K-1:0]  ka, kb;
    logic                 sa, sb, za, zb, na, nb;
    logic signed [RB-1:0] x_raw;
    logic signed [K-1:0]  x_k;
    logic [ES-1:0]        x_e;
    logic                 x_sign, x_nar, x_zero, x_ovf, x_unf;
  } vec_t;

  vec_t vecs[NV];
  vec_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  posit_exp_combiner #(.ES(ES), .K_BITS(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .exp_A(exp_A), .exp_B(exp_B), .k_A(k_A), .k_B(k_B),
    .sign_A(sign_A), .sign_B(sign_B), .zero_A(zero_A), .zero_B(zero_B),
    .nar_A(nar_A), .nar_B(nar_B), .ack(ack),
    .exp_raw(exp_raw), .k_out(k_out), .e_out(e_out), .sign_out(sign_out),
    .nar_out(nar_out), .zero_out(zero_out), .ovf(ovf), .unf(unf),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_result(input vec_t v, input string tag);
    check({tag, " exp_raw"}, 32'(exp_raw), 32'(v.x_raw));
    check({tag, " k_out"},   32'(k_out),   32'(v.x_k));
    check({tag, " e_out"},   32'(e_out),   32'(v.x_e));
    check({tag, " flags"},   32'({sign_out, nar_out, zero_out, ovf, unf}),
          32'({v.x_sign, v.x_nar, v.x_zero, v.x_ovf, v.x_unf}));
  endtask

  task automatic drive(input vec_t v);
    op = v.op; exp_A = v.ea; exp_B = v.eb; k_A = v.ka; k_B = v.kb;
    sign_A = v.sa; sign_B = v.sb; zero_A = v.za; zero_B = v.zb; nar_A = v.na; nar_B = v.nb;
  endtask

  // Counts rising edges after the start-sampling edge until done, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop_and_check(input string tag);
    vec_t e;
    check({tag, " sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_result(e, tag);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    drive(v);
    start = 1'b1;
    sb_q.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), 32'd2);
    pop_and_check(tag);
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk); #1;
    check({tag, " done_clr"}, 32'({done, busy}), 32'd0);
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    int lat;
    vecs[0]  = '{1'b0, 3'd3, 3'd5, 6'sd2,   -6'sd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  10'sd16,  6'sd2,   3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'd7, 3'd0, 6'sd31,  6'sd1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  10'sd255, 6'sd31,  3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 3'd0, 3'd0, -6'sd32, 6'sd1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -10'sd256, -6'sd32, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 3'd2, 3'd1, 6'sd3,   6'sd2,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  10'sd0,   6'sd0,   3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd4, 3'd1, 6'sd1,   6'sd2,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  10'sd0,   6'sd0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 3'd0, 6'sd1,   6'sd1,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,  10'sd0,   6'sd0,   3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 3'd2, 3'd4, 6'sd1,   -6'sd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  10'sd22,  6'sd2,   3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'd7, 3'd0, 6'sd31,  6'sd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  10'sd255, 6'sd31,  3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 3'd0, -6'sd32, 6'sd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -10'sd256, -6'sd32, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd1, 3'd2, -6'sd3,  6'sd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -10'sd21,  -6'sd3,  3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'd5, 3'd6, 6'sd4,   -6'sd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,  10'sd0,   6'sd0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 3'd5, 3'd6, 6'sd4,   -6'sd7,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  10'sd0,   6'sd0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'd7, 3'd7, 6'sd31,  6'sd31,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  10'sd255, 6'sd31,  3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 3'd7, 3'd0, 6'sd31,  -6'sd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  10'sd255, 6'sd31,  3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 3'd3, 3'd3, 6'sd2,   6'sd2,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  10'sd0,   6'sd0,   3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 3'd0, 3'd7, -6'sd32, 6'sd31,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -10'sd256, -6'sd32, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 3'd7, 3'd7, 6'sd31,  6'sd31,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  10'sd0,   6'sd0,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'({exp_raw, k_out, e_out}), 32'd0);
    check("reset flags", 32'({sign_out, nar_out, zero_out, ovf, unf, done, busy}), 32'd0);
    #1 rst_n = 1'b1;

    // Table: start is accepted on the first edge after reset release
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Handshake: long ack delay, inputs and start toggling while busy
    @(negedge clk);
    drive(vecs[0]);
    start = 1'b1;
    sb_q.push_back(vecs[0]);
    @(posedge clk); #1;
    drive(vecs[1]);
    wait_done(lat);
    check("hs latency", 32'(lat), 32'd2);
    pop_and_check("hs");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start = ~start;
      check($sformatf("hs hold%0d done", c), 32'({done, busy}), 32'd3);
      check_result(vecs[0], $sformatf("hs hold%0d", c));
    end
    @(negedge clk);
    start = 1'b1;
    ack = 1'b1;
    @(posedge clk); #1;
    check("hs ack done_busy", 32'({done, busy}), 32'd0);
    check_result(vecs[0], "hs kept");
    @(negedge clk);
    start = 1'b0;
    ack = 1'b0;
    @(posedge clk); #1;
    check("hs idle busy", 32'(busy), 32'd0);
    // Stray ack in IDLE must not disturb the next operation
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("ack in idle", 32'({done, busy}), 32'd0);

    // Reset while in CALC, then an immediate restart
    @(negedge clk);
    drive(vecs[1]);
    start = 1'b1;
    sb_q.push_back(vecs[1]);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("mid reset outputs", 32'({exp_raw, k_out, e_out}), 32'd0);
    check("mid reset flags", 32'({sign_out, nar_out, zero_out, ovf, unf, done, busy}), 32'd0);
    @(posedge clk); #1;
    check("reset held busy", 32'({done, busy}), 32'd0);
    #1 rst_n = 1'b1;
    run_vec(vecs[6], "post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
